axi4_l1_interconnect_n: RTL and testbench

Parametrised N-master to 1-slave AXI4 interconnect for multi-core A23 clusters, generalising the fixed two-port L1 interconnect. It arbitrates independently on AR and AW with round-robin fairness. It extends transaction IDs with a master-index prefix and routes W data in AW-grant order through a bounded FIFO. R and B responses are steered back by ID prefix. It sits between N `axi4_a23_core_mp` instances and the cluster's outbound `axi4_if.master`.

---
 rtl/axi4_ic_pkg.sv | 11 +
 rtl/axi4_if.sv | 48 ++++
 rtl/axi4_rr_arb.sv | 56 +++++
 rtl/axi4_l1_interconnect_n.sv | 119 +++++++++++
 tb/tb_axi4_l1_interconnect_n.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_ic_pkg.sv
// Shared types and helpers for the N-master AXI4 L1 interconnect.
package axi4_ic_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  // Width of the master-index prefix prepended to outbound IDs.
  function automatic int ic_id_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 bundle used on both the per-core upstream ports and the outbound port.
interface axi4_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 3
);
  logic              ARVALID, ARREADY;
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;

  logic              AWVALID, AWREADY;
  logic [ID_W-1:0]   AWID;
  logic [ADDR_W-1:0] AWADDR;
  logic [7:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;

  logic                WVALID, WREADY, WLAST;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;

  logic              RVALID, RREADY, RLAST;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;

  logic            BVALID, BREADY;
  logic [ID_W-1:0] BID;
  logic [1:0]      BRESP;

  modport master (
    output ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, input ARREADY,
    output AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST, input AWREADY,
    output WVALID, WDATA, WSTRB, WLAST, input WREADY,
    input  RVALID, RID, RDATA, RRESP, RLAST, output RREADY,
    input  BVALID, BID, BRESP, output BREADY
  );
  modport slave (
    input  ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, output ARREADY,
    input  AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST, output AWREADY,
    input  WVALID, WDATA, WSTRB, WLAST, output WREADY,
    output RVALID, RID, RDATA, RRESP, RLAST, input RREADY,
    output BVALID, BID, BRESP, input BREADY
  );
endinterface

// File: rtl/axi4_rr_arb.sv
// Round-robin address-channel arbiter; holds its grant while VALID waits on READY.
module axi4_rr_arb
  import axi4_ic_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = ic_id_bits(N)
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_block,
  input  logic          i_ready,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  arb_state_e      r_state, w_state_nx;
  logic [IW-1:0]   r_idx, r_ptr, w_pick;
  logic [IW:0]     w_off, w_sum;
  logic [2*N-1:0]  w_rot;

  // Rotate so bit 0 is the master at r_ptr, then take the lowest set bit.
  always_comb begin
    w_rot = {i_req, i_req} >> r_ptr;
    w_off = '0;
    for (int k = N - 1; k >= 0; k--)
      if (w_rot[k]) w_off = (IW+1)'(k);
    w_sum  = {1'b0, r_ptr} + w_off;
    w_pick = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
  end

  assign o_idx   = (r_state == ARB_LOCKED) ? r_idx : w_pick;
  assign o_valid = (r_state == ARB_LOCKED) ? i_req[r_idx] : (|i_req & ~i_block);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ARB_IDLE:   if (o_valid && !i_ready) w_state_nx = ARB_LOCKED;
      ARB_LOCKED: if (!o_valid || i_ready) w_state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == ARB_IDLE) r_idx <= w_pick;
      if (o_valid && i_ready)
        r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/axi4_l1_interconnect_n.sv
// N-master to 1-slave AXI4 interconnect: RR address arbitration, AW-ordered W routing,
// ID-prefix response steering.
module axi4_l1_interconnect_n
  import axi4_ic_pkg::*;
#(
  parameter int N_MASTERS          = 4,
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 3,
  parameter int WR_DEPTH           = 4
) (
  input  logic   clk_i,
  input  logic   rst_n,
  axi4_if.slave  m [N_MASTERS],
  axi4_if.master out,
  output logic   o_route_err
);

  localparam int MB  = ic_id_bits(N_MASTERS);
  localparam int IDW = AXI4_ID_WIDTH;
  localparam int APW = IDW + AXI4_ADDRESS_WIDTH + 13;
  localparam int WPW = AXI4_DATA_WIDTH + AXI4_DATA_WIDTH / 8 + 1;
  localparam int PW  = ic_id_bits(WR_DEPTH);
  localparam int CW  = $clog2(WR_DEPTH + 1);

  logic [N_MASTERS-1:0]          w_ar_req, w_aw_req, w_w_vld, w_r_rdy, w_b_rdy;
  logic [N_MASTERS-1:0][APW-1:0] w_ar_pl, w_aw_pl;
  logic [N_MASTERS-1:0][WPW-1:0] w_w_pl;
  logic [MB-1:0]  w_ar_idx, w_aw_idx, w_w_head, w_r_sel, w_b_sel;
  logic [IDW-1:0] w_ar_id, w_aw_id;
  logic w_ar_vld, w_aw_vld, w_aw_hs, w_aw_full, w_w_act, w_w_pop, w_r_ok, w_b_ok;

  logic [WR_DEPTH-1:0][MB-1:0] r_fifo;
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_route_err;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_port
    // Gate requests with reset so nothing is forwarded while reset is held.
    assign w_ar_req[i]  = m[i].ARVALID & rst_n;
    assign w_ar_pl[i]   = {m[i].ARID, m[i].ARADDR, m[i].ARLEN, m[i].ARSIZE, m[i].ARBURST};
    assign m[i].ARREADY = w_ar_vld & out.ARREADY & (w_ar_idx == MB'(i));
    assign w_aw_req[i]  = m[i].AWVALID & rst_n;
    assign w_aw_pl[i]   = {m[i].AWID, m[i].AWADDR, m[i].AWLEN, m[i].AWSIZE, m[i].AWBURST};
    assign m[i].AWREADY = w_aw_vld & out.AWREADY & (w_aw_idx == MB'(i));
    assign w_w_vld[i]   = m[i].WVALID;
    assign w_w_pl[i]    = {m[i].WDATA, m[i].WSTRB, m[i].WLAST};
    assign m[i].WREADY  = w_w_act & out.WREADY & (w_w_head == MB'(i));
    assign w_r_rdy[i]   = m[i].RREADY;
    assign m[i].RVALID  = out.RVALID & (w_r_sel == MB'(i));
    assign m[i].RID     = out.RID[IDW-1:0];
    assign m[i].RDATA   = out.RDATA;
    assign m[i].RRESP   = out.RRESP;
    assign m[i].RLAST   = out.RLAST;
    assign w_b_rdy[i]   = m[i].BREADY;
    assign m[i].BVALID  = out.BVALID & (w_b_sel == MB'(i));
    assign m[i].BID     = out.BID[IDW-1:0];
    assign m[i].BRESP   = out.BRESP;
  end

  axi4_rr_arb #(.N(N_MASTERS)) u_ar_arb (
    .clk_i(clk_i), .rst_n(rst_n), .i_req(w_ar_req), .i_block(1'b0),
    .i_ready(out.ARREADY), .o_idx(w_ar_idx), .o_valid(w_ar_vld)
  );

  axi4_rr_arb #(.N(N_MASTERS)) u_aw_arb (
    .clk_i(clk_i), .rst_n(rst_n), .i_req(w_aw_req), .i_block(w_aw_full),
    .i_ready(out.AWREADY), .o_idx(w_aw_idx), .o_valid(w_aw_vld)
  );

  assign out.ARVALID = w_ar_vld;
  assign {w_ar_id, out.ARADDR, out.ARLEN, out.ARSIZE, out.ARBURST} = w_ar_pl[w_ar_idx];
  assign out.ARID    = {w_ar_idx, w_ar_id};
  assign out.AWVALID = w_aw_vld;
  assign {w_aw_id, out.AWADDR, out.AWLEN, out.AWSIZE, out.AWBURST} = w_aw_pl[w_aw_idx];
  assign out.AWID    = {w_aw_idx, w_aw_id};

  // W follows AW-grant order: the FIFO head names the master whose burst is current.
  assign w_aw_hs   = w_aw_vld & out.AWREADY;
  assign w_aw_full = (r_cnt == CW'(WR_DEPTH));
  assign w_w_act   = (r_cnt != '0);
  assign w_w_head  = r_fifo[r_rp];
  assign out.WVALID = w_w_act & w_w_vld[w_w_head];
  assign {out.WDATA, out.WSTRB, out.WLAST} = w_w_pl[w_w_head];
  assign w_w_pop   = out.WVALID & out.WREADY & out.WLAST;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_aw_hs) begin
        r_fifo[r_wp] <= w_aw_idx;
        r_wp <= (r_wp == PW'(WR_DEPTH - 1)) ? '0 : r_wp + 1'b1;
      end
      if (w_w_pop) r_rp <= (r_rp == PW'(WR_DEPTH - 1)) ? '0 : r_rp + 1'b1;
      if (w_aw_hs && !w_w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_aw_hs && w_w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Beats with a prefix beyond the last master are sunk so the slave never stalls.
  assign w_r_sel   = out.RID[IDW +: MB];
  assign w_b_sel   = out.BID[IDW +: MB];
  assign w_r_ok    = (int'(w_r_sel) < N_MASTERS);
  assign w_b_ok    = (int'(w_b_sel) < N_MASTERS);
  assign out.RREADY = w_r_ok ? w_r_rdy[w_r_sel] : 1'b1;
  assign out.BREADY = w_b_ok ? w_b_rdy[w_b_sel] : 1'b1;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) r_route_err <= 1'b0;
    else if ((out.RVALID && !w_r_ok) || (out.BVALID && !w_b_ok)) r_route_err <= 1'b1;
  end

  assign o_route_err = r_route_err;

endmodule

// File: tb/tb_axi4_l1_interconnect_n.sv
// Directed bench for axi4_l1_interconnect_n: arbitration, W ordering, FIFO limit,
// response steering, bad prefix and asynchronous reset.
module tb_axi4_l1_interconnect_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  axi4_if #(.ADDR_W(32), .DATA_W(32), .ID_W(3)) mi [4] ();
  axi4_if #(.ADDR_W(32), .DATA_W(32), .ID_W(5)) so ();
  axi4_if #(.ADDR_W(32), .DATA_W(32), .ID_W(3)) mi3 [3] ();
  axi4_if #(.ADDR_W(32), .DATA_W(32), .ID_W(5)) so3 ();
  logic err4, err3;

  axi4_l1_interconnect_n #(.N_MASTERS(4), .WR_DEPTH(4)) dut (
    .clk_i(clk), .rst_n(rst_n), .m(mi), .out(so), .o_route_err(err4));
  axi4_l1_interconnect_n #(.N_MASTERS(3), .WR_DEPTH(4)) dut3 (
    .clk_i(clk), .rst_n(rst_n), .m(mi3), .out(so3), .o_route_err(err3));

  logic [3:0]       ar_v = '0, aw_v = '0, w_v = '0, w_last = '0, r_rdy = '0, b_rdy = '0;
  logic [3:0][2:0]  ar_id, aw_id;
  logic [3:0][31:0] ar_addr, aw_addr, w_data;
  logic [3:0][7:0]  aw_len;
  logic [3:0]       ar_rdy_o, aw_rdy_o, w_rdy_o, r_v_o, b_v_o;
  logic [3:0][2:0]  r_id_o, b_id_o;
  logic [2:0]       b3_v_o;
  logic s_arready = 0, s_awready = 0, s_wready = 0, s_rvalid = 0, s_bvalid = 0, s3_bvalid = 0;
  logic [4:0] s_rid = '0, s_bid = '0, s3_bid = '0;

  for (genvar g = 0; g < 4; g++) begin : g_m
    assign mi[g].ARVALID = ar_v[g];   assign mi[g].ARID = ar_id[g];
    assign mi[g].ARADDR = ar_addr[g]; assign mi[g].ARLEN = 8'd0;
    assign mi[g].ARSIZE = 3'd2;       assign mi[g].ARBURST = 2'b01;
    assign mi[g].AWVALID = aw_v[g];   assign mi[g].AWID = aw_id[g];
    assign mi[g].AWADDR = aw_addr[g]; assign mi[g].AWLEN = aw_len[g];
    assign mi[g].AWSIZE = 3'd2;       assign mi[g].AWBURST = 2'b01;
    assign mi[g].WVALID = w_v[g];     assign mi[g].WDATA = w_data[g];
    assign mi[g].WSTRB = 4'hF;        assign mi[g].WLAST = w_last[g];
    assign mi[g].RREADY = r_rdy[g];   assign mi[g].BREADY = b_rdy[g];
    assign ar_rdy_o[g] = mi[g].ARREADY; assign aw_rdy_o[g] = mi[g].AWREADY;
    assign w_rdy_o[g]  = mi[g].WREADY;  assign r_v_o[g] = mi[g].RVALID;
    assign r_id_o[g]   = mi[g].RID;     assign b_v_o[g] = mi[g].BVALID;
    assign b_id_o[g]   = mi[g].BID;
  end

  for (genvar g = 0; g < 3; g++) begin : g_m3
    assign mi3[g].ARVALID = 1'b0; assign mi3[g].ARID = '0; assign mi3[g].ARADDR = '0;
    assign mi3[g].ARLEN = '0;     assign mi3[g].ARSIZE = '0; assign mi3[g].ARBURST = '0;
    assign mi3[g].AWVALID = 1'b0; assign mi3[g].AWID = '0; assign mi3[g].AWADDR = '0;
    assign mi3[g].AWLEN = '0;     assign mi3[g].AWSIZE = '0; assign mi3[g].AWBURST = '0;
    assign mi3[g].WVALID = 1'b0;  assign mi3[g].WDATA = '0; assign mi3[g].WSTRB = '0;
    assign mi3[g].WLAST = 1'b0;   assign mi3[g].RREADY = 1'b0; assign mi3[g].BREADY = 1'b0;
    assign b3_v_o[g] = mi3[g].BVALID;
  end

  assign so.ARREADY = s_arready; assign so.AWREADY = s_awready; assign so.WREADY = s_wready;
  assign so.RVALID = s_rvalid;   assign so.RID = s_rid;   assign so.RDATA = 32'hCAFE0001;
  assign so.RRESP = 2'b00;       assign so.RLAST = 1'b1;
  assign so.BVALID = s_bvalid;   assign so.BID = s_bid;   assign so.BRESP = 2'b00;
  assign so3.ARREADY = 1'b0; assign so3.AWREADY = 1'b0; assign so3.WREADY = 1'b0;
  assign so3.RVALID = 1'b0;  assign so3.RID = '0; assign so3.RDATA = '0;
  assign so3.RRESP = '0;     assign so3.RLAST = 1'b0;
  assign so3.BVALID = s3_bvalid; assign so3.BID = s3_bid; assign so3.BRESP = '0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    ar_v = 4'hF; aw_v = 4'hF; s_arready = 1; s_awready = 1;
    #1;
    checks++; if (so.ARVALID !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%b exp=0", so.ARVALID); end
    checks++; if (so.AWVALID !== 1'b0) begin failures++; $display("FAIL reset_awvalid got=%b exp=0", so.AWVALID); end
    checks++; if (so.WVALID !== 1'b0) begin failures++; $display("FAIL reset_wvalid got=%b exp=0", so.WVALID); end
    checks++; if (ar_rdy_o !== 4'h0 || aw_rdy_o !== 4'h0) begin failures++; $display("FAIL reset_ready got=%b/%b exp=0", ar_rdy_o, aw_rdy_o); end
    checks++; if (err4 !== 1'b0 || err3 !== 1'b0) begin failures++; $display("FAIL reset_err got=%b%b exp=00", err4, err3); end
    ar_v = 0; aw_v = 0; s_arready = 0; s_awready = 0;
    tick(); rst_n = 1'b1; tick();
  endtask

  task automatic test_rr_ar();
    logic [4:0] e_id;
    ar_v = 4'hF; s_arready = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      e_id = {2'(k % 4), 3'(4 + k % 4)};
      checks++; if (so.ARID !== e_id) begin failures++; $display("FAIL rr_arid[%0d] got=%h exp=%h", k, so.ARID, e_id); end
      checks++; if (ar_rdy_o !== 4'(1 << (k % 4))) begin failures++; $display("FAIL rr_arready[%0d] got=%b exp=%b", k, ar_rdy_o, 4'(1 << (k % 4))); end
      tick();
    end
    ar_v = 4'b1000; #1;  // moves the pointer back to 0
    checks++; if (so.ARID[4:3] !== 2'd3) begin failures++; $display("FAIL rr_only3 got=%0d exp=3", so.ARID[4:3]); end
    tick();
  endtask

  task automatic test_lock();
    ar_v = 4'b0010; s_arready = 0; #1;
    checks++; if (so.ARID !== 5'b01_101) begin failures++; $display("FAIL lock_first got=%h exp=%h", so.ARID, 5'b01_101); end
    tick();
    ar_v = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (so.ARADDR !== ar_addr[1] || so.ARID !== 5'b01_101 || ar_rdy_o !== 4'h0) begin
        failures++; $display("FAIL lock_hold[%0d] got=%h/%h/%b exp=%h/%h/0000", k, so.ARADDR, so.ARID, ar_rdy_o, ar_addr[1], 5'b01_101); end
      tick();
    end
    s_arready = 1; #1;
    checks++; if (ar_rdy_o !== 4'b0010) begin failures++; $display("FAIL lock_hs got=%b exp=0010", ar_rdy_o); end
    tick();
    ar_v = 4'b0101; #1;
    checks++; if (so.ARID[4:3] !== 2'd2) begin failures++; $display("FAIL lock_next got=%0d exp=2", so.ARID[4:3]); end
    tick();
    ar_v = 0; s_arready = 0;
  endtask

  task automatic test_w_order();
    w_v = 4'b0101; w_last = 4'b0000; w_data[2] = 32'h2000_0000; w_data[0] = 32'hA0;
    s_wready = 1; #1;
    checks++; if (so.WVALID !== 1'b0 || w_rdy_o !== 4'h0) begin failures++; $display("FAIL w_early got=%b/%b exp=0/0000", so.WVALID, w_rdy_o); end
    s_wready = 0; aw_v = 4'b0100; aw_len[2] = 8'd3; s_awready = 1; #1;
    checks++; if (so.AWID !== 5'b10_010 || so.AWLEN !== 8'd3) begin failures++; $display("FAIL aw_m2 got=%h/%0d exp=%h/3", so.AWID, so.AWLEN, 5'b10_010); end
    tick();
    aw_v = 4'b0001; aw_len[0] = 8'd1; #1;
    checks++; if (so.AWID !== 5'b00_000) begin failures++; $display("FAIL aw_m0 got=%h exp=00", so.AWID); end
    tick();
    aw_v = 0; s_awready = 0; s_wready = 1;
    for (int k = 0; k < 4; k++) begin
      w_data[2] = 32'h2000_0000 + 32'(k); w_last[2] = (k == 3); #1;
      checks++; if (so.WVALID !== 1'b1 || so.WDATA !== 32'h2000_0000 + 32'(k) || so.WLAST !== (k == 3) || w_rdy_o !== 4'b0100) begin
        failures++; $display("FAIL w_m2[%0d] got=%b/%h/%b/%b exp=1/%h/%b/0100", k, so.WVALID, so.WDATA, so.WLAST, w_rdy_o, 32'h2000_0000 + 32'(k), k == 3); end
      tick();
    end
    w_v[2] = 0;
    for (int k = 0; k < 2; k++) begin
      w_data[0] = 32'hA0 + 32'(k); w_last[0] = (k == 1); #1;
      checks++; if (so.WDATA !== 32'hA0 + 32'(k) || w_rdy_o !== 4'b0001) begin
        failures++; $display("FAIL w_m0[%0d] got=%h/%b exp=%h/0001", k, so.WDATA, w_rdy_o, 32'hA0 + 32'(k)); end
      tick();
    end
    #1;
    checks++; if (so.WVALID !== 1'b0) begin failures++; $display("FAIL w_drained got=%b exp=0", so.WVALID); end
    w_v = 0; s_wready = 0;
  endtask

  task automatic test_fifo_full();
    aw_v = 4'b0001; s_awready = 1; aw_len[0] = 8'd0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (aw_rdy_o !== 4'b0001) begin failures++; $display("FAIL full_fill[%0d] got=%b exp=0001", k, aw_rdy_o); end
      tick();
    end
    #1;
    checks++; if (aw_rdy_o !== 4'h0 || so.AWVALID !== 1'b0) begin failures++; $display("FAIL full_block got=%b/%b exp=0000/0", aw_rdy_o, so.AWVALID); end
    tick();
    w_v[0] = 1; w_last[0] = 1; w_data[0] = 32'h55; s_wready = 1; #1;
    checks++; if (aw_rdy_o !== 4'h0 || w_rdy_o !== 4'b0001) begin failures++; $display("FAIL full_pop got=%b/%b exp=0000/0001", aw_rdy_o, w_rdy_o); end
    tick();
    s_wready = 0; #1;
    checks++; if (aw_rdy_o !== 4'b0001) begin failures++; $display("FAIL full_unblock got=%b exp=0001", aw_rdy_o); end
    tick();
    aw_v = 0; s_awready = 0; s_wready = 1;
    repeat (4) tick();
    #1;
    checks++; if (so.WVALID !== 1'b0) begin failures++; $display("FAIL full_drain got=%b exp=0", so.WVALID); end
    w_v = 0; w_last = 0; s_wready = 0;
  endtask

  task automatic test_resp();
    s_rvalid = 1; s_rid = {2'd3, 3'd5}; r_rdy = 4'b1000; #1;
    checks++; if (r_v_o !== 4'b1000 || r_id_o[3] !== 3'd5) begin failures++; $display("FAIL r_route got=%b/%0d exp=1000/5", r_v_o, r_id_o[3]); end
    checks++; if (so.RREADY !== 1'b1) begin failures++; $display("FAIL r_ready_hi got=%b exp=1", so.RREADY); end
    r_rdy = 4'b0111; #1;
    checks++; if (so.RREADY !== 1'b0) begin failures++; $display("FAIL r_ready_lo got=%b exp=0", so.RREADY); end
    s_rvalid = 0; s_bvalid = 1; s_bid = {2'd1, 3'd2}; b_rdy = 4'b0010; #1;
    checks++; if (b_v_o !== 4'b0010 || b_id_o[1] !== 3'd2 || so.BREADY !== 1'b1) begin
      failures++; $display("FAIL b_route got=%b/%0d/%b exp=0010/2/1", b_v_o, b_id_o[1], so.BREADY); end
    tick();
    s_bvalid = 0; r_rdy = 0; b_rdy = 0;
    checks++; if (err4 !== 1'b0) begin failures++; $display("FAIL r_no_err got=%b exp=0", err4); end
  endtask

  task automatic test_bad_prefix_reset();
    s3_bvalid = 1; s3_bid = {2'd3, 3'd0}; #1;
    checks++; if (so3.BREADY !== 1'b1 || b3_v_o !== 3'b000) begin failures++; $display("FAIL bad_sink got=%b/%b exp=1/000", so3.BREADY, b3_v_o); end
    tick();
    s3_bvalid = 0; tick();
    checks++; if (err3 !== 1'b1) begin failures++; $display("FAIL bad_sticky got=%b exp=1", err3); end
    aw_v = 4'b0010; s_awready = 1; tick();
    aw_v = 0; s_awready = 0; w_v[1] = 1; ar_v = 4'b1010; #1;
    checks++; if (so.WVALID !== 1'b1 || so.ARVALID !== 1'b1) begin failures++; $display("FAIL pre_reset got=%b/%b exp=1/1", so.WVALID, so.ARVALID); end
    #2; rst_n = 1'b0; #1;
    checks++; if (so.WVALID !== 1'b0 || so.ARVALID !== 1'b0 || err3 !== 1'b0) begin
      failures++; $display("FAIL mid_reset got=%b/%b/%b exp=0/0/0", so.WVALID, so.ARVALID, err3); end
    tick(); rst_n = 1'b1; #1;
    checks++; if (so.ARID[4:3] !== 2'd1 || so.WVALID !== 1'b0) begin
      failures++; $display("FAIL post_reset got=%0d/%b exp=1/0", so.ARID[4:3], so.WVALID); end
    ar_v = 0; w_v = 0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      ar_id[i] = 3'(4 + i); ar_addr[i] = 32'h1000 * (i + 1);
      aw_id[i] = 3'(i);     aw_addr[i] = 32'h8000 + 32'h100 * i;
      aw_len[i] = 8'd0;     w_data[i] = '0;
    end
    test_reset();
    test_rr_ar();
    test_lock();
    test_w_order();
    test_fifo_full();
    test_resp();
    test_bad_prefix_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
